i2c_xfer_arbiter: RTL

Shares one byte-level I2C master engine between NUM_REQ requesters, round-robin, with each grant held for a whole transaction. Latches the winner's address, direction and length. Sequences the engine through START, address byte, data bytes and STOP, then reports completion or NAK error to the owner. Sits between the system-side command sources and the I2C master engine that drives scl/sda toward the slave BFM.

---
 rtl/i2c_xfer_arbiter_if.sv | 20 ++
 rtl/i2c_xfer_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/i2c_xfer_arbiter_if.sv
// Command/response channel between the transaction arbiter and the byte-level I2C engine.
interface i2c_xfer_arbiter_if;
  logic [2:0] eng_cmd_o;
  logic [7:0] eng_wdata_o;
  logic       eng_valid_o;
  logic       eng_ready_i;
  logic       eng_done_i;
  logic       eng_nak_i;
  logic [7:0] eng_rdata_i;

  modport master (
    output eng_cmd_o, eng_wdata_o, eng_valid_o,
    input  eng_ready_i, eng_done_i, eng_nak_i, eng_rdata_i
  );

  modport slave (
    input  eng_cmd_o, eng_wdata_o, eng_valid_o,
    output eng_ready_i, eng_done_i, eng_nak_i, eng_rdata_i
  );
endinterface

// File: rtl/i2c_xfer_arbiter.sv
// Round-robin owner of a shared I2C byte engine; sequences START, address,
// data bytes and STOP for the granted requester and reports done/NAK.
module i2c_xfer_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int LEN_W   = 4,
  parameter int GNT_W   = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [7*NUM_REQ-1:0]     req_addr_i,
  input  logic [NUM_REQ-1:0]       req_rw_i,
  input  logic [LEN_W*NUM_REQ-1:0] req_len_i,
  input  logic [8*NUM_REQ-1:0]     req_wdata_i,
  output logic [NUM_REQ-1:0]       wr_pop_o,
  output logic [7:0]               rd_data_o,
  output logic                     rd_valid_o,
  output logic [NUM_REQ-1:0]       gnt_o,
  output logic [GNT_W-1:0]         gnt_idx_o,
  output logic [NUM_REQ-1:0]       done_o,
  output logic                     err_o,
  i2c_xfer_arbiter_if.master       eng
);

  localparam int unsigned NR = NUM_REQ;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_WDATA, S_RDATA, S_STOP, S_FIN
  } state_e;

  typedef enum logic [2:0] {
    CMD_NONE  = 3'd0,
    CMD_START = 3'd1,
    CMD_STOP  = 3'd2,
    CMD_WRITE = 3'd3,
    CMD_RACK  = 3'd4,
    CMD_RNAK  = 3'd5
  } cmd_e;

  state_e             r_state;
  cmd_e               r_cmd;
  logic [7:0]         r_wdata;
  logic               r_valid;
  logic               r_wait;
  logic [GNT_W-1:0]   r_ptr;
  logic [GNT_W-1:0]   r_gnt_idx;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] r_done;
  logic               r_err;
  logic               r_err_o;
  logic [6:0]         r_addr;
  logic               r_rw;
  logic [LEN_W-1:0]   r_cnt;
  logic [7:0]         r_rd_data;
  logic               r_rd_valid;

  logic               w_req_any;
  logic [GNT_W-1:0]   w_req_idx;
  logic [GNT_W-1:0]   w_cand;
  logic [GNT_W-1:0]   w_ptr_nxt;
  logic [NUM_REQ-1:0] w_pop;

  // First pending requester at or after the pointer, wrapping.
  always_comb begin
    w_req_any = 1'b0;
    w_req_idx = '0;
    w_cand    = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      w_cand = GNT_W'((32'(r_ptr) + k) % NR);
      if (!w_req_any && req_i[w_cand]) begin
        w_req_any = 1'b1;
        w_req_idx = w_cand;
      end
    end
  end

  assign w_ptr_nxt = (w_req_idx == GNT_W'(NR - 1)) ? '0 : w_req_idx + 1'b1;

  always_comb begin
    w_pop = '0;
    if (r_state == S_WDATA && r_valid && eng.eng_ready_i) w_pop = r_gnt;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_cmd      <= CMD_NONE;
      r_wdata    <= '0;
      r_valid    <= 1'b0;
      r_wait     <= 1'b0;
      r_ptr      <= '0;
      r_gnt_idx  <= '0;
      r_gnt      <= '0;
      r_done     <= '0;
      r_err      <= 1'b0;
      r_err_o    <= 1'b0;
      r_addr     <= '0;
      r_rw       <= 1'b0;
      r_cnt      <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_done     <= '0;
      r_err_o    <= 1'b0;
      r_rd_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req_any) begin
            r_gnt     <= NUM_REQ'(1) << w_req_idx;
            r_gnt_idx <= w_req_idx;
            r_ptr     <= w_ptr_nxt;
            r_addr    <= req_addr_i[7*w_req_idx +: 7];
            r_rw      <= req_rw_i[w_req_idx];
            r_cnt     <= req_len_i[LEN_W*w_req_idx +: LEN_W];
            r_err     <= 1'b0;
            r_state   <= S_START;
          end
        end
        // Each command state: raise valid, hold until accepted, then wait for done.
        S_START, S_ADDR, S_WDATA, S_RDATA, S_STOP: begin
          if (!r_valid && !r_wait) begin
            r_valid <= 1'b1;
            case (r_state)
              S_START: begin r_cmd <= CMD_START; r_wdata <= '0; end
              S_ADDR:  begin r_cmd <= CMD_WRITE; r_wdata <= {r_addr, r_rw}; end
              S_WDATA: begin r_cmd <= CMD_WRITE; r_wdata <= req_wdata_i[8*r_gnt_idx +: 8]; end
              S_RDATA: begin
                r_cmd   <= (r_cnt > LEN_W'(1)) ? CMD_RACK : CMD_RNAK;
                r_wdata <= '0;
              end
              default: begin r_cmd <= CMD_STOP; r_wdata <= '0; end
            endcase
          end else if (r_valid) begin
            if (eng.eng_ready_i) begin
              r_valid <= 1'b0;
              r_wait  <= 1'b1;
            end
          end else if (eng.eng_done_i) begin
            r_wait <= 1'b0;
            case (r_state)
              S_START: r_state <= S_ADDR;
              S_ADDR: begin
                if (eng.eng_nak_i) begin
                  r_err   <= 1'b1;
                  r_state <= S_STOP;
                end else if (r_cnt == '0) r_state <= S_STOP;
                else if (r_rw)            r_state <= S_RDATA;
                else                      r_state <= S_WDATA;
              end
              S_WDATA: begin
                if (eng.eng_nak_i) begin
                  r_err   <= 1'b1;
                  r_state <= S_STOP;
                end else begin
                  r_cnt <= r_cnt - 1'b1;
                  if (r_cnt == LEN_W'(1)) r_state <= S_STOP;
                end
              end
              S_RDATA: begin
                r_rd_data  <= eng.eng_rdata_i;
                r_rd_valid <= 1'b1;
                r_cnt      <= r_cnt - 1'b1;
                if (r_cnt == LEN_W'(1)) r_state <= S_STOP;
              end
              default: begin
                r_done  <= r_gnt;
                r_err_o <= r_err;
                r_state <= S_FIN;
              end
            endcase
          end
        end
        S_FIN: begin
          r_gnt     <= '0;
          r_gnt_idx <= '0;
          r_err     <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign eng.eng_cmd_o   = r_cmd;
  assign eng.eng_wdata_o = r_wdata;
  assign eng.eng_valid_o = r_valid;
  assign wr_pop_o        = w_pop;
  assign rd_data_o       = r_rd_data;
  assign rd_valid_o      = r_rd_valid;
  assign gnt_o           = r_gnt;
  assign gnt_idx_o       = r_gnt_idx;
  assign done_o          = r_done;
  assign err_o           = r_err_o;

endmodule
